// File: rtl/riscv_str_arb.sv
// Two-requester round-robin arbiter in front of a shared string unit.
// One request is in flight at a time: it is granted in IDLE, issued to the
// unit, optionally waited on (LEET), and answered through the owner's
// response channel.

package riscv_defines;

  localparam int unsigned STR_OP_WIDTH = 3;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd4;

endpackage

module riscv_str_arb
  import riscv_defines::*;
#(
  parameter int unsigned LEET_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req0_valid_i,
  input  logic [STR_OP_WIDTH-1:0] req0_op_i,
  input  logic [31:0]             req0_operand_i,
  output logic                    req0_ready_o,
  output logic                    rsp0_valid_o,
  output logic [31:0]             rsp0_result_o,
  output logic                    rsp0_err_o,
  input  logic                    rsp0_ready_i,

  input  logic                    req1_valid_i,
  input  logic [STR_OP_WIDTH-1:0] req1_op_i,
  input  logic [31:0]             req1_operand_i,
  output logic                    req1_ready_o,
  output logic                    rsp1_valid_o,
  output logic [31:0]             rsp1_result_o,
  output logic                    rsp1_err_o,
  input  logic                    rsp1_ready_i,

  output logic                    str_enable_o,
  output logic [STR_OP_WIDTH-1:0] str_operator_o,
  output logic [31:0]             str_operand_o,
  input  logic [31:0]             str_result_i,
  input  logic                    str_ready_i,
  output logic                    str_ex_ready_o,
  output logic                    busy_o
);

  localparam logic [31:0] ErrorResult = 32'hDEADBEEF;
  localparam logic [7:0]  WaitLast    = 8'(LEET_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    prio_q, prio_d;      // 1: req1 wins a tie
  logic                    owner_q, owner_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             operand_q, operand_d;
  logic [31:0]             result_q, result_d;
  logic                    err_q, err_d;
  logic [7:0]              waitCnt_q, waitCnt_d;

  logic                    idleActive;
  logic                    grant0;
  logic                    grant1;
  logic [STR_OP_WIDTH-1:0] grantOp;
  logic [31:0]             grantOperand;
  logic                    rspTaken;
  logic                    strEnable;
  logic                    exReady;
  logic                    inResp;

  function automatic logic isKnownOp(input logic [STR_OP_WIDTH-1:0] op);
    return (op == STR_OP_UPPER) || (op == STR_OP_LOWER) ||
           (op == STR_OP_ROT13) || (op == STR_OP_LEET);
  endfunction

  // Grants are only possible in IDLE; rst_n gates them so that a valid
  // request held during reset never sees its ready asserted.
  assign idleActive   = (state_q == IDLE) && rst_n;
  assign grant0       = idleActive && req0_valid_i && (!req1_valid_i || !prio_q);
  assign grant1       = idleActive && req1_valid_i && (!req0_valid_i ||  prio_q);
  assign grantOp      = grant1 ? req1_op_i      : req0_op_i;
  assign grantOperand = grant1 ? req1_operand_i : req0_operand_i;
  assign rspTaken     = owner_q ? rsp1_ready_i : rsp0_ready_i;

  // Next-state logic: sequences one request from grant to response.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    op_d      = op_q;
    operand_d = operand_q;
    result_d  = result_q;
    err_d     = err_q;
    waitCnt_d = waitCnt_q;
    strEnable = 1'b0;
    exReady   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d   = grant1;
          prio_d    = !grant1;
          op_d      = grantOp;
          operand_d = grantOperand;
          if (isKnownOp(grantOp)) begin
            state_d = ISSUE;
          end else begin
            result_d = ErrorResult;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end

      ISSUE: begin
        strEnable = 1'b1;
        if (op_q == STR_OP_LEET) begin
          waitCnt_d = 8'd0;
          state_d   = WAIT;
        end else begin
          result_d = str_result_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end
      end

      WAIT: begin
        strEnable = 1'b1;
        if (str_ready_i) begin
          result_d = str_result_i;
          err_d    = 1'b0;
          exReady  = 1'b1;
          state_d  = RESP;
        end else if (waitCnt_q == WaitLast) begin
          result_d = ErrorResult;
          err_d    = 1'b1;
          exReady  = 1'b1;
          state_d  = RESP;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      RESP: begin
        if (rspTaken) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers; reset clears everything, even mid-WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      op_q      <= '0;
      operand_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      err_q     <= err_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign inResp = (state_q == RESP);

  assign req0_ready_o   = grant0;
  assign req1_ready_o   = grant1;

  // The unit bus is zeroed whenever the unit is not enabled.
  assign str_enable_o   = strEnable;
  assign str_operator_o = strEnable ? op_q      : '0;
  assign str_operand_o  = strEnable ? operand_q : '0;
  assign str_ex_ready_o = exReady;
  assign busy_o         = (state_q != IDLE);

  // Only the owner's response channel carries data; the other stays at zero.
  assign rsp0_valid_o   = inResp && !owner_q;
  assign rsp0_result_o  = rsp0_valid_o ? result_q : '0;
  assign rsp0_err_o     = rsp0_valid_o && err_q;

  assign rsp1_valid_o   = inResp && owner_q;
  assign rsp1_result_o  = rsp1_valid_o ? result_q : '0;
  assign rsp1_err_o     = rsp1_valid_o && err_q;

endmodule

// File: tb/tb_riscv_str_arb.sv
// Testbench for riscv_str_arb: a behavioural string unit, directed latency
// cases, randomized two-requester traffic and a reset-during-WAIT case.
// Expected responses are queued per requester at grant time and a monitor
// pops and compares them whenever a response is presented.

module tb_riscv_str_arb;
  import riscv_defines::*;

  localparam int          LeetTimeout = 16;
  localparam int          GrantBound  = 400;
  localparam logic [31:0] ErrWord     = 32'hDEADBEEF;

  typedef logic [STR_OP_WIDTH-1:0] op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0_valid = 1'b0;
  op_t         req0_op = '0;
  logic [31:0] req0_operand = '0;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_result;
  logic        rsp0_err;
  logic        rsp0_ready = 1'b0;

  logic        req1_valid = 1'b0;
  op_t         req1_op = '0;
  logic [31:0] req1_operand = '0;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_result;
  logic        rsp1_err;
  logic        rsp1_ready = 1'b0;

  logic        str_enable;
  op_t         str_operator;
  logic [31:0] str_operand;
  logic [31:0] str_result;
  logic        str_ready;
  logic        str_ex_ready;
  logic        busy;

  int          assertCount = 0;
  int          failCount = 0;

  logic [32:0] expQ0[$];
  logic [32:0] expQ1[$];

  bit          randomReady = 1'b0;
  bit          forceReady0 = 1'b1;
  bit          forceReady1 = 1'b1;
  bit          prioModel = 1'b0;

  logic [7:0]  leetCnt = '0;

  riscv_str_arb #(.LEET_TIMEOUT(LeetTimeout)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid_i   (req0_valid),
    .req0_op_i      (req0_op),
    .req0_operand_i (req0_operand),
    .req0_ready_o   (req0_ready),
    .rsp0_valid_o   (rsp0_valid),
    .rsp0_result_o  (rsp0_result),
    .rsp0_err_o     (rsp0_err),
    .rsp0_ready_i   (rsp0_ready),
    .req1_valid_i   (req1_valid),
    .req1_op_i      (req1_op),
    .req1_operand_i (req1_operand),
    .req1_ready_o   (req1_ready),
    .rsp1_valid_o   (rsp1_valid),
    .rsp1_result_o  (rsp1_result),
    .rsp1_err_o     (rsp1_err),
    .rsp1_ready_i   (rsp1_ready),
    .str_enable_o   (str_enable),
    .str_operator_o (str_operator),
    .str_operand_o  (str_operand),
    .str_result_i   (str_result),
    .str_ready_i    (str_ready),
    .str_ex_ready_o (str_ex_ready),
    .busy_o         (busy)
  );

  initial forever #5 clk = ~clk;

  // Character transforms of the string unit.
  function automatic logic [7:0] charMap(input op_t op, input logic [7:0] c);
    logic [7:0] r;
    r = c;
    case (op)
      STR_OP_UPPER: if (c >= 8'h61 && c <= 8'h7A) r = c - 8'd32;
      STR_OP_LOWER: if (c >= 8'h41 && c <= 8'h5A) r = c + 8'd32;
      STR_OP_ROT13: begin
        if (c >= 8'h41 && c <= 8'h5A) r = 8'h41 + ((c - 8'h41 + 8'd13) % 8'd26);
        if (c >= 8'h61 && c <= 8'h7A) r = 8'h61 + ((c - 8'h61 + 8'd13) % 8'd26);
      end
      STR_OP_LEET: begin
        case (c)
          8'h65:   r = 8'h33;
          8'h73:   r = 8'h35;
          8'h6C:   r = 8'h31;
          8'h6F:   r = 8'h30;
          8'h74:   r = 8'h37;
          default: r = c;
        endcase
      end
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] unitWord(input op_t op, input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = charMap(op, w[8*b +: 8]);
    return r;
  endfunction

  // Reference model: unknown ops and LEET on a hanging operand (top byte FF)
  // produce the error word; everything else is the unit's transform.
  function automatic logic [32:0] refModel(input op_t op, input logic [31:0] w);
    if (op < STR_OP_UPPER || op > STR_OP_LEET) return {1'b1, ErrWord};
    if (op == STR_OP_LEET && w[31:24] == 8'hFF) return {1'b1, ErrWord};
    return {1'b0, unitWord(op, w)};
  endfunction

  // String unit: combinational result; LEET becomes ready on its fifth
  // enabled cycle, except for operands whose top byte is FF, which hang.
  always @(posedge clk) begin
    if (str_enable && str_operator == STR_OP_LEET) begin
      if (leetCnt != 8'hFF) leetCnt <= leetCnt + 8'd1;
    end else begin
      leetCnt <= '0;
    end
  end

  assign str_ready  = !(str_enable && str_operator == STR_OP_LEET) ||
                      (leetCnt >= 8'd4 && str_operand[31:24] != 8'hFF);
  assign str_result = unitWord(str_operator, str_operand);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"}, {57'd0, req0_ready, req1_ready, rsp0_valid, rsp0_err,
                                  rsp1_valid, rsp1_err, busy}, 64'd0);
    checkOutput({name, "_rsp_data"}, {rsp0_result, rsp1_result}, 64'd0);
    checkOutput({name, "_str_bus"}, {27'd0, str_enable, str_ex_ready, str_operator, str_operand}, 64'd0);
  endtask

  // Drives one request, queues its expected response on grant, then
  // withdraws it. patience==0 waits for a grant up to GrantBound cycles.
  task automatic applyStimulus(input int n, input op_t op, input logic [31:0] operand,
                               input logic [32:0] expected, input int patience, output bit granted);
    int  waited;
    bit  seen;
    granted = 1'b0;
    waited  = 0;
    @(posedge clk); #1;
    if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_operand = operand; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_operand = operand; end
    while (!granted) begin
      @(negedge clk);
      seen = (n == 0) ? req0_ready : req1_ready;
      if (seen) begin
        granted = 1'b1;
        if (n == 0) expQ0.push_back(expected);
        else        expQ1.push_back(expected);
      end else begin
        waited++;
        if (patience > 0 && waited >= patience) break;
        if (waited >= GrantBound) begin
          checkOutput($sformatf("grant_wait_req%0d", n), {63'd0, seen}, 64'd1);
          break;
        end
      end
    end
    @(posedge clk); #1;
    if (n == 0) begin req0_valid = 1'b0; req0_op = '0; req0_operand = '0; end
    else        begin req1_valid = 1'b0; req1_op = '0; req1_operand = '0; end
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput({name, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic applyReset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    expQ0.delete();
    expQ1.delete();
    rst_n = 1'b1;
  endtask

  // Single request with response ready held high: checks latency from the
  // accept cycle, number and position of ex_ready pulses, and enabled cycles.
  task automatic runDirected(input string name, input int n, input op_t op, input logic [31:0] operand,
                             input logic [31:0] expRes, input bit expErr, input int expLat,
                             input int expPulses, input int expPulseAt);
    bit granted;
    bit gotRsp;
    int lat, pulses, pulseAt, enables;
    applyStimulus(n, op, operand, {expErr, expRes}, 0, granted);
    if (!granted) return;
    lat = 0; pulses = 0; pulseAt = 0; enables = 0; gotRsp = 1'b0;
    while (!gotRsp && lat < 100) begin
      @(negedge clk);
      lat++;
      if (str_ex_ready) begin pulses++; pulseAt = lat; end
      if (str_enable) enables++;
      gotRsp = (n == 0) ? rsp0_valid : rsp1_valid;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, "_ex_pulses"}, 64'(pulses), 64'(expPulses));
    checkOutput({name, "_ex_pulse_cycle"}, 64'(pulseAt), 64'(expPulseAt));
    checkOutput({name, "_enable_cycles"}, 64'(enables), 64'(expLat - 1));
    waitIdle(name);
  endtask

  task automatic randomDriver(input int n, input int count);
    op_t         op;
    logic [31:0] operand;
    int          patience;
    bit          granted;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = op_t'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = STR_OP_LEET;
      operand = $urandom();
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 2) != 0)
          operand[8*b +: 8] = 8'(32'h41 + $urandom_range(0, 25) + ($urandom_range(0, 1) ? 32 : 0));
      if (op == STR_OP_LEET && $urandom_range(0, 4) == 0) operand[31:24] = 8'hFF;
      patience = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(n, op, operand, refModel(op, operand), patience, granted);
    end
  endtask

  // Response-ready driver: forced levels in directed phases, random otherwise.
  initial forever begin
    @(posedge clk); #1;
    if (randomReady) begin
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
    end else begin
      rsp0_ready = forceReady0;
      rsp1_ready = forceReady1;
    end
  end

  // Monitor: arbitration order, response scoreboard and bus invariants.
  initial forever begin
    bit expOwner;
    @(negedge clk);
    if (!rst_n) begin
      prioModel = 1'b0;
      continue;
    end
    if (!busy && (req0_valid || req1_valid)) begin
      expOwner = (req0_valid && req1_valid) ? prioModel : req1_valid;
      checkOutput("rr_grant", {62'd0, req1_ready, req0_ready}, expOwner ? 64'd2 : 64'd1);
      prioModel = !expOwner;
    end else begin
      checkOutput("no_grant", {62'd0, req1_ready, req0_ready}, 64'd0);
    end

    if (rsp0_valid) begin
      checkOutput("rsp0_expected", {63'd0, expQ0.size() != 0}, 64'd1);
      if (expQ0.size() != 0) begin
        checkOutput("rsp0_data", {31'd0, rsp0_err, rsp0_result}, {31'd0, expQ0[0]});
        if (rsp0_ready) void'(expQ0.pop_front());
      end
      checkOutput("rsp1_quiet", {30'd0, rsp1_valid, rsp1_err, rsp1_result}, 64'd0);
    end else if (rsp1_valid) begin
      checkOutput("rsp1_expected", {63'd0, expQ1.size() != 0}, 64'd1);
      if (expQ1.size() != 0) begin
        checkOutput("rsp1_data", {31'd0, rsp1_err, rsp1_result}, {31'd0, expQ1[0]});
        if (rsp1_ready) void'(expQ1.pop_front());
      end
      checkOutput("rsp0_quiet", {30'd0, rsp0_valid, rsp0_err, rsp0_result}, 64'd0);
    end else begin
      checkOutput("rsp_idle_zero", {rsp0_result, rsp1_result} | {62'd0, rsp0_err, rsp1_err}, 64'd0);
    end

    if (!str_enable)
      checkOutput("str_idle_zero", {28'd0, str_ex_ready, str_operator, str_operand}, 64'd0);
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit granted;
    bit gotRsp;
    int cycles;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed cases");
    runDirected("upper",   0, STR_OP_UPPER, 32'h64636261, 32'h44434241, 1'b0, 2, 0, 0);
    runDirected("leet",    1, STR_OP_LEET,  32'h6C736541, 32'h31353341, 1'b0, 6, 1, 5);
    runDirected("lower",   1, STR_OP_LOWER, 32'h44434241, 32'h64636261, 1'b0, 2, 0, 0);
    runDirected("timeout", 0, STR_OP_LEET,  32'hFF656C73, ErrWord, 1'b1, LeetTimeout + 2, 1, LeetTimeout + 1);
    runDirected("bad_op0", 1, op_t'(0),     32'h12345678, ErrWord, 1'b1, 1, 0, 0);
    runDirected("bad_op7", 0, op_t'(7),     32'h6C6C6C6C, ErrWord, 1'b1, 1, 0, 0);

    $display("[TB] simultaneous requests after reset");
    applyReset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = STR_OP_ROT13; req0_operand = 32'h41414141;
    req1_valid = 1'b1; req1_op = STR_OP_ROT13; req1_operand = 32'h41414141;
    @(negedge clk);
    checkOutput("dual_first_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
    if (req0_ready) expQ0.push_back({1'b0, 32'h4E4E4E4E});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    cycles = 1;
    gotRsp = 1'b0;
    while (!gotRsp && cycles < 50) begin
      @(negedge clk);
      if (req1_ready) begin gotRsp = 1'b1; expQ1.push_back({1'b0, 32'h4E4E4E4E}); end
      else cycles++;
    end
    checkOutput("dual_second_grant_cycle", 64'(cycles), 64'd3);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    waitIdle("dual");

    $display("[TB] randomized traffic");
    randomReady = 1'b1;
    fork
      randomDriver(0, 40);
      randomDriver(1, 40);
    join
    randomReady = 1'b0;
    for (int i = 0; i < 2000 && (busy || expQ0.size() != 0 || expQ1.size() != 0); i++)
      @(negedge clk);
    checkOutput("drain_q0", 64'(expQ0.size()), 64'd0);
    checkOutput("drain_q1", 64'(expQ1.size()), 64'd0);

    $display("[TB] reset during WAIT");
    forceReady0 = 1'b1;
    applyStimulus(0, STR_OP_LEET, 32'hFF736C65, {1'b1, ErrWord}, 0, granted);
    repeat (3) @(negedge clk);
    checkOutput("prereset_in_wait", {62'd0, busy, str_enable}, 64'd3);
    #1;
    rst_n = 1'b0;
    req1_valid = 1'b1; req1_op = STR_OP_UPPER; req1_operand = 32'h64636261;
    #1;
    checkAllZero("mid_wait_reset");
    @(negedge clk);
    @(posedge clk); #1;
    checkAllZero("held_reset");
    req1_valid = 1'b0; req1_op = '0; req1_operand = '0;
    expQ0.delete();
    expQ1.delete();
    forceReady0 = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(0, STR_OP_UPPER, 32'h64636261, {1'b0, 32'h44434241}, 0, granted);
    gotRsp = 1'b0;
    for (int i = 0; i < 20 && !gotRsp; i++) begin
      @(negedge clk);
      gotRsp = rsp0_valid;
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("held_rsp_cycle%0d", k), {30'd0, rsp0_valid, rsp0_err, rsp0_result},
                  {30'd0, 1'b1, 1'b0, 32'h44434241});
      @(negedge clk);
    end
    forceReady0 = 1'b1;
    waitIdle("held_rsp");
    checkOutput("final_q0", 64'(expQ0.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
